timer_arbiter: RTL and testbench
================================

// Module: timer_arbiter
// PURPOSE
//   One shared prescaled down-counter timer, time-shared between NREQ requesters.
//   Each requester asks for a delay of D ticks; a tick is PRESCALE clk_i cycles.
//   A round-robin arbiter grants the timer to one requester at a time.
//   The grant ends with a one-cycle done pulse to that requester.
//   The block replaces one clock divider per client with a single shared timebase.
// PARAMETERS
//   NREQ      4    number of requesters (2..8)
//   PRESCALE  500  clk_i cycles per tick (>=2)
//   CNT_W     16   width of each requested delay, in ticks
// PORTS
//   clk_i    in   1           the block's only clock
//   rst_ni   in   1           reset: synchronous, active-low
//   req_i    in   NREQ        request level per requester; held until done_o or abort
//   delay_i  in   NREQ*CNT_W  delay in ticks; requester k uses [k*CNT_W +: CNT_W]
//   gnt_o    out  NREQ        one-hot; high for the owner while the FSM is in RUN
//   done_o   out  NREQ        one-hot, one-cycle pulse when the owner's delay has expired
//   busy_o   out  1           high in every state except IDLE
//   tick_o   out  1           one-cycle pulse on each prescaler wrap in RUN
// BEHAVIOUR
//   Reset (rst_ni=0 at a clk_i edge):
//     - state=IDLE; prescaler=0; remaining=0; rr_ptr=0; owner=0
//     - all outputs 0; reset wins over every other event, in any state
//   Arbitration (IDLE only):
//     - search req_i from index rr_ptr upward, wrapping modulo NREQ
//     - the first set bit wins; owner <= winner
//     - remaining <= delay_i[winner]; prescaler <= 0
//     - next state is RUN, or DONE if the latched delay is 0
//     - delay_i is sampled only in this cycle; later changes are ignored
//   RUN:
//     - gnt_o[owner]=1 (Moore); prescaler counts 0..PRESCALE-1 and wraps to 0
//     - tick = (prescaler==PRESCALE-1); tick_o=tick; on tick, remaining decrements
//     - if tick and remaining==1: next state DONE
//     - if req_i[owner]==0: abort, checked before the tick test
//       -> next state IDLE, no done pulse, rr_ptr <= owner+1 mod NREQ
//   DONE (one cycle):
//     - done_o[owner]=1, gnt_o=0
//     - rr_ptr <= owner+1 mod NREQ; next state IDLE
//     - arbitration restarts in the following IDLE cycle, so a 1-cycle IDLE gap
//       always sits between grants
//   Latency, with t0 = the IDLE cycle in which the winner is sampled:
//     - gnt_o is high from t0+1 through t0+D*PRESCALE
//     - ticks occur at t0+k*PRESCALE, k=1..D
//     - done_o is high at t0+D*PRESCALE+1
//     - D=0: no grant, no tick; done_o at t0+1
//   Fairness:
//     - a requester that keeps req_i high is granted within NREQ-1 other grants
//     - when the owner re-requests at once, it goes to the back of the order
//   Width rules:
//     - remaining is CNT_W bits and never underflows (D=0 is handled in IDLE)
//     - prescaler width is $clog2(PRESCALE); D=2^CNT_W-1 is supported
//   Boundary conditions:
//     - req_i for non-owners is ignored outside IDLE
//     - req_i dropping in the DONE cycle has no effect
//     - all req_i low in IDLE: stay in IDLE, rr_ptr unchanged
// TESTING (bench uses PRESCALE=4, NREQ=4, CNT_W=8)
//   1. req_i=0001, D0=3, sampled at t0:
//      gnt_o=0001 for t0+1..t0+12; tick_o at t0+4/8/12; done_o=0001 at t0+13; busy_o=0 at t0+14
//   2. req_i=1111 held, all D=1 after reset:
//      grant order 0,1,2,3,0; each grant is 4 cycles; 1 IDLE cycle between DONE and the next grant
//   3. D2=0, req_i=0100:
//      done_o=0100 one cycle after sampling; gnt_o and tick_o never assert
//   4. owner 1 (D=5) drops req_i[1] at t0+6:
//      IDLE at t0+7; no done_o; a pending req_i[2] wins next with rr_ptr=2
//   5. rst_ni=0 mid-RUN (t0+5), D=3:
//      next cycle all outputs 0 and state IDLE; after release, requester 0 wins first (rr_ptr=0)
//   6. D=255 with PRESCALE=4:
//      done_o exactly 1021 cycles after t0; remaining never wraps

Source files
------------

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//   One prescaled down-counter timer shared between NREQ requesters.
//   A requester raises req_i[k] with a delay of D ticks on its delay_i slot.
//   A round-robin arbiter hands the timer to one requester at a time. While
//   that requester owns the timer, gnt_o shows it. When its delay runs out it
//   gets a one-cycle done_o pulse.
//
//   Request protocol (level, no ready):
//     req_i[k] is a level that stays high until done_o[k] pulses or the
//     requester aborts. An abort is req_i[k] falling while k owns the timer.
//     An abort ends the grant at once and produces no done pulse. Outside
//     IDLE, req_i of non-owners is not looked at. delay_i[k] is sampled
//     only in the IDLE cycle in which k wins arbitration.
//
// Ports
//   clk_i    in   1            clock
//   rst_ni   in   1            synchronous, active-low reset
//   req_i    in   NREQ         request level per requester
//   delay_i  in   NREQ*CNT_W   delay in ticks; requester k uses [k*CNT_W +: CNT_W]
//   gnt_o    out  NREQ         one-hot owner indication while running
//   done_o   out  NREQ         one-hot, one-cycle expiry pulse
//   busy_o   out  1            high whenever the FSM is not in IDLE
//   tick_o   out  1            one-cycle pulse on each prescaler wrap while running
//
// The FSM state is held in state_q (type state_e) for checkers that bind to it.
// -----------------------------------------------------------------------------
module timer_arbiter #(
  parameter int NREQ     = 4,
  parameter int PRESCALE = 500,
  parameter int CNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*CNT_W-1:0] delay_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic                  busy_o,
  output logic                  tick_o
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int PS_W  = $clog2(PRESCALE);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;

  // Arbitration results, only meaningful in IDLE.
  logic               any_req;
  logic [PTR_W-1:0]   win_idx;
  logic [CNT_W-1:0]   win_delay;

  logic               tick;
  logic [PTR_W-1:0]   owner_plus1;
  logic [NREQ-1:0]    owner_oh;

  // ---------------------------------------------------------------------------
  // Round-robin search: start at rr_q, walk upward with wrap. The first set
  // request bit wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    win_idx = rr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_q) + i) % NREQ;
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  assign win_delay = delay_i[int'(win_idx)*CNT_W +: CNT_W];

  // The prescaler wraps on the same cycle that the tick fires.
  assign tick = (state_q == ST_RUN) && (presc_q == PS_LAST);

  // The owner goes to the back of the order, whether it completed or aborted.
  assign owner_plus1 = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);

  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      remain_q <= '0;
      rr_q     <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    rr_d     = rr_q;
    owner_d  = owner_q;

    unique case (state_q)
      ST_IDLE: begin
        // With no request, stay put and leave the pointer untouched.
        if (any_req) begin
          owner_d  = win_idx;
          remain_d = win_delay;
          presc_d  = '0;
          // A zero delay never enters RUN. This keeps remain_q from underflowing.
          state_d  = (win_delay == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (!req_i[owner_q]) begin
          // An abort takes priority over a tick in the same cycle.
          state_d = ST_IDLE;
          rr_d    = owner_plus1;
        end else begin
          presc_d = tick ? '0 : presc_q + PS_W'(1);
          if (tick) begin
            remain_d = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        // req_i is ignored here. IDLE always follows, which leaves a
        // one-cycle gap between grants.
        rr_d    = owner_plus1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore, apart from tick_o which also depends on the prescaler)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    busy_o = (state_q != ST_IDLE);
    tick_o = tick;
    if (state_q == ST_RUN) begin
      gnt_o = owner_oh;
    end
    if (state_q == ST_DONE) begin
      done_o = owner_oh;
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
//   Scoreboard bench for timer_arbiter (NREQ=4, PRESCALE=4, CNT_W=8).
//
//   The reference model describes each grant by timestamps. A grant is
//   sampled at cycle t0 with delay D. The owner is granted for
//   t0+1 .. t0+D*P, ticks fall on multiples of P after t0, and done falls
//   on t0+D*P+1. An abort or a reset cancels the grant.
//
//   For every cycle, the model pushes the expected {gnt, done, busy, tick}
//   word into exp_q. The monitor pops one word on each falling edge and
//   compares it with the DUT outputs.
//
//   Directed scenarios add explicit latency, order and abort checks. A
//   randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int P    = 4;
  localparam int CW   = 8;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NREQ-1:0]      req_i = '0;
  logic [NREQ*CW-1:0]   delay_i = '0;
  logic [NREQ-1:0]      gnt_o, done_o;
  logic                 busy_o, tick_o;

  always #5 clk = ~clk;

  timer_arbiter #(.NREQ(NREQ), .PRESCALE(P), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .delay_i(delay_i),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .busy_o (busy_o),
    .tick_o (tick_o)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  int         chk = 0;
  int         err = 0;

  // Stimulus that the driver applies in the next cycle.
  logic [NREQ-1:0]    s_req = '0;
  logic [NREQ*CW-1:0] s_delay = '0;
  logic               s_rst = 1'b0;

  // ---------------- reference model ----------------
  int  n = 0;          // index of the current cycle (cycle n follows posedge n)
  bit  m_busy = 0;     // a grant is in progress (RUN or the done cycle)
  int  m_t0 = 0;
  int  m_d = 0;
  int  m_owner = 0;
  int  m_rr = 0;

  task automatic model_push();
    logic [9:0] w;
    logic [3:0] oh;
    int e;
    w = '0;
    if (m_busy) begin
      e  = n - m_t0;
      oh = 4'(1 << m_owner);
      if (e >= 1 && e <= m_d * P) w = {oh, 4'b0000, 1'b1, 1'((e % P) == 0)};
      else                        w = {4'b0000, oh, 1'b1, 1'b0};
    end
    exp_q.push_back(w);
  endtask

  task automatic model_step();
    int  e;
    bit  found;
    if (!rst_ni) begin
      m_busy = 0;
      m_rr   = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_i[(m_rr + i) % NREQ]) begin
          found   = 1;
          m_owner = (m_rr + i) % NREQ;
        end
      end
      if (found) begin
        m_busy = 1;
        m_t0   = n;
        m_d    = int'(delay_i[m_owner*CW +: CW]);
      end
    end else begin
      e = n - m_t0;
      if (e == m_d * P + 1 || !req_i[m_owner]) begin
        m_busy = 0;
        m_rr   = (m_owner + 1) % NREQ;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    n++;
    model_push();
    req_i   = s_req;
    delay_i = s_delay;
    rst_ni  = s_rst;
    model_step();
  endtask

  task automatic check(input string name, input int act, input int expv);
    chk++;
    if (act !== expv) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, n);
    end
  endtask

  task automatic wait_done(input int k, input int maxc, output int dc);
    dc = -1;
    for (int i = 0; i < maxc; i++) begin
      if (dc < 0) begin
        cycle();
        if (done_o[k]) dc = n;
      end
    end
  endtask

  task automatic idle_cycles(input int c);
    s_req = '0;
    for (int i = 0; i < c; i++) cycle();
  endtask

  task automatic do_reset();
    s_rst = 1'b0;
    cycle();
    s_rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [9:0] w;
    logic [9:0] act;
    if (exp_q.size() > 0) begin
      w   = exp_q.pop_front();
      act = {gnt_o, done_o, busy_o, tick_o};
      chk++;
      if (act !== w) begin
        err++;
        $display("FAIL cycle_out: cycle %0d got gnt=%b done=%b busy=%b tick=%b expected gnt=%b done=%b busy=%b tick=%b",
                 n, act[9:6], act[5:2], act[1], act[0], w[9:6], w[5:2], w[1], w[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int dc;
    int order[$];
    int exp_order[5];
    logic [NREQ-1:0] prev_g;

    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    s_rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("reset_outputs", int'({gnt_o, done_o, busy_o, tick_o}), 0);
    s_rst = 1'b1;
    cycle();

    // 1: single request, D=3
    s_delay = '0;
    s_delay[0*CW +: CW] = 8'd3;
    s_req = 4'b0001;
    cycle();
    t0 = n;
    wait_done(0, 30, dc);
    check("t1_done_latency", dc - t0, 3 * P + 1);
    s_req = '0;
    cycle();
    check("t1_busy_after", int'(busy_o), 0);
    idle_cycles(2);

    // 2: all request with D=1 after reset; grant order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < NREQ; k++) s_delay[k*CW +: CW] = 8'd1;
    s_req  = 4'b1111;
    prev_g = '0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (gnt_o != '0 && prev_g == '0 && order.size() < 5) begin
        for (int k = 0; k < NREQ; k++) if (gnt_o[k]) order.push_back(k);
      end
      prev_g = gnt_o;
    end
    check("t2_grant_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      check("t2_grant_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    idle_cycles(5);

    // 3: zero delay gives done with no grant
    s_delay[2*CW +: CW] = 8'd0;
    s_req = 4'b0100;
    cycle();
    cycle();
    check("t3_done_zero_delay", int'(done_o), 4);
    check("t3_no_gnt", int'(gnt_o), 0);
    idle_cycles(3);

    // 4: owner 1 (D=5) aborts at t0+6; pending requester 2 wins next
    do_reset();
    s_delay[1*CW +: CW] = 8'd5;
    s_delay[2*CW +: CW] = 8'd2;
    s_req = 4'b0010;
    cycle();
    t0 = n;
    s_req = 4'b0110;
    for (int i = 0; i < 5; i++) cycle();
    s_req = 4'b0100;
    cycle();
    check("t4_abort_cycle", n - t0, 6);
    cycle();
    check("t4_idle_after_abort", int'({busy_o, done_o}), 0);
    cycle();
    check("t4_next_owner", int'(gnt_o), 4);
    idle_cycles(12);

    // 5: reset mid-RUN, then requester 0 wins first
    do_reset();
    s_delay[0*CW +: CW] = 8'd3;
    s_req = 4'b0001;
    cycle();
    t0 = n;
    for (int i = 0; i < 4; i++) cycle();
    s_rst = 1'b0;
    cycle();
    s_rst = 1'b1;
    s_req = 4'b1111;
    cycle();
    check("t5_reset_mid_run", int'({gnt_o, done_o, busy_o, tick_o}), 0);
    cycle();
    check("t5_first_after_reset", int'(gnt_o), 1);
    idle_cycles(4);

    // 6: maximum delay 255
    do_reset();
    s_delay[0*CW +: CW] = 8'd255;
    s_req = 4'b0001;
    cycle();
    t0 = n;
    wait_done(0, 1100, dc);
    check("t6_done_latency_max", dc - t0, 255 * P + 1);
    idle_cycles(3);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!s_req[k]) begin
          if ($urandom_range(0, 2) == 0) s_req[k] = 1'b1;
        end else if ($urandom_range(0, 29) == 0) begin
          s_req[k] = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) s_delay[k*CW +: CW] = 8'($urandom_range(0, 3));
      end
      s_rst = ($urandom_range(0, 499) != 0);
      cycle();
    end
    s_rst = 1'b1;
    idle_cycles(20);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
